sqrt_result_buffer: RTL and testbench

- Downstream consumer of the square-root unit.
- Captures each 8-bit root when the unit's done strobe (its ready output) rises, and queues it in a small FIFO.
- Presents results to the next stage over a valid/ready handshake.
- Decouples the root producer from a consumer that may stall; reports overflow when a result has to be dropped.

---
 rtl/sqrt_pkg.sv | 13 +
 rtl/sqrt_result_buffer_if.sv | 15 +
 rtl/sqrt_result_fifo.sv | 65 ++++++
 rtl/sqrt_result_buffer.sv | 91 +++++++++
 tb/tb_sqrt_result_buffer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sqrt_pkg.sv
// Shared constants for the square-root unit and its result buffer.
package sqrt_pkg;

    localparam int ROOT_W            = 8;
    localparam int VALUE_W           = 16;
    localparam int DEFAULT_RES_DEPTH = 4;

    // Count register width: one extra bit so that full and empty are distinct.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sqrt_result_buffer_if.sv
// Valid/ready result handshake between the result buffer and the next stage.
interface sqrt_result_buffer_if
    import sqrt_pkg::*;
#(
    parameter int W = sqrt_pkg::ROOT_W
);

    logic [W-1:0] res_data;
    logic         res_valid;
    logic         res_ready;

    modport master (output res_data, output res_valid, input res_ready);
    modport slave  (input res_data, input res_valid, output res_ready);

endinterface

// File: rtl/sqrt_result_fifo.sv
// Generic first-word-fall-through FIFO: storage, wrapping pointers and occupancy count.
module sqrt_result_fifo
    import sqrt_pkg::*;
#(
    parameter int DEPTH = DEFAULT_RES_DEPTH,
    parameter int W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          push,
    input  logic                          pop,
    input  logic [W-1:0]                  wdata,
    output logic [W-1:0]                  rdata,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is allowed when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sqrt_result_buffer.sv
// Captures square-root results on the rising edge of done_i and queues them for a stalling consumer.
// Optional SQRT_DROP_CNT_EN adds a saturating count of dropped results on drop_cnt_o.
module sqrt_result_buffer
    import sqrt_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_RES_DEPTH,
    parameter int ROOT_W = sqrt_pkg::ROOT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ROOT_W-1:0]             root_i,
    input  logic                          done_i,
    sqrt_result_buffer_if.master          res,
    output logic [count_width(DEPTH)-1:0] count_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          overflow_o,
    input  logic                          clear_i
`ifdef SQRT_DROP_CNT_EN
    ,
    output logic [7:0]                    drop_cnt_o
`endif
);

    logic done_q;
    logic armed;
    logic cap;
    logic pop;
    logic push_req;
    logic push;
    logic drop;

    // armed stays low for the first cycle after reset so a done_i already
    // high at release is sampled into done_q instead of being captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            done_q <= done_i;
            armed  <= 1'b1;
        end
    end

    assign cap      = done_i & ~done_q & armed;
    assign pop      = res.res_valid & res.res_ready;
    assign push_req = cap & ~clear_i;
    assign push     = push_req & (~full_o | pop);
    assign drop     = push_req & full_o & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            overflow_o <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
        end
    end

`ifdef SQRT_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_o <= '0;
        end else if (clear_i) begin
            drop_cnt_o <= '0;
        end else if (drop && (drop_cnt_o != 8'hFF)) begin
            drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end
`endif

    sqrt_result_fifo #(
        .DEPTH (DEPTH),
        .W     (ROOT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_i),
        .push  (push),
        .pop   (pop),
        .wdata (root_i),
        .rdata (res.res_data),
        .full  (full_o),
        .empty (empty_o),
        .count (count_o)
    );

    assign res.res_valid = ~empty_o;

endmodule

// File: tb/tb_sqrt_result_buffer.sv
// Directed and randomized bench for sqrt_result_buffer against a queue-based reference model.
module tb_sqrt_result_buffer;
    import sqrt_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] root_i;
    logic       done_i;
    logic [2:0] count_o;
    logic       full_o;
    logic       empty_o;
    logic       overflow_o;
    logic       clear_i;
`ifdef SQRT_DROP_CNT_EN
    logic [7:0] drop_cnt_o;
`endif

    sqrt_result_buffer_if bus ();

    sqrt_result_buffer #(.DEPTH(DEPTH), .ROOT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .root_i     (root_i),
        .done_i     (done_i),
        .res        (bus.master),
        .count_o    (count_o),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .overflow_o (overflow_o),
        .clear_i    (clear_i)
`ifdef SQRT_DROP_CNT_EN
        ,
        .drop_cnt_o (drop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a queue of results plus the edge-detect history.
    logic [7:0] q[$];
    bit         m_prev;
    bit         m_armed;
    bit         m_ovf;
    int         m_drops;
    int         total = 0;
    int         bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_prev  = 1'b0;
        m_armed = 1'b0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    task automatic check_output();
        check_eq("count", 32'(count_o), 32'(q.size()));
        check_eq("empty", 32'(empty_o), 32'(q.size() == 0));
        check_eq("full", 32'(full_o), 32'(q.size() == DEPTH));
        check_eq("valid", 32'(bus.res_valid), 32'(q.size() != 0));
        check_eq("overflow", 32'(overflow_o), 32'(m_ovf));
        if (q.size() != 0) check_eq("data", 32'(bus.res_data), 32'(q[0]));
`ifdef SQRT_DROP_CNT_EN
        check_eq("drop_cnt", 32'(drop_cnt_o), 32'(m_drops));
`endif
    endtask

    // One clock: advance the model from the current inputs, then compare.
    task automatic apply_stimulus();
        bit cap;
        bit pop;
        if (rst) begin
            model_reset();
        end else begin
            cap = done_i && !m_prev && m_armed;
            pop = (q.size() != 0) && bus.res_ready;
            if (clear_i) begin
                q.delete();
                m_ovf   = 1'b0;
                m_drops = 0;
            end else begin
                if (pop) void'(q.pop_front());
                if (cap) begin
                    if (q.size() < DEPTH) q.push_back(root_i);
                    else begin
                        m_ovf = 1'b1;
                        if (m_drops < 255) m_drops++;
                    end
                end
            end
            m_prev  = done_i;
            m_armed = 1'b1;
        end
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic pulse_capture(input logic [7:0] v);
        root_i = v;
        done_i = 1'b1;
        apply_stimulus();
        done_i = 1'b0;
        apply_stimulus();
    endtask

    initial begin
        rst          = 1'b1;
        root_i       = '0;
        done_i       = 1'b0;
        clear_i      = 1'b0;
        bus.res_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_output();
        check_eq("rst_data", 32'(bus.res_data), 32'd0);
        rst = 1'b0;
        apply_stimulus();

        // Single-cycle done pulse: result visible one clock later.
        root_i = 8'd12;
        done_i = 1'b1;
        apply_stimulus();
        check_eq("t1_data", 32'(bus.res_data), 32'd12);
        check_eq("t1_count", 32'(count_o), 32'd1);
        done_i = 1'b0;
        bus.res_ready = 1'b1;
        apply_stimulus();
        bus.res_ready = 1'b0;

        // Held done gives a single capture; re-arm after one low cycle.
        root_i = 8'd7;
        done_i = 1'b1;
        repeat (5) apply_stimulus();
        check_eq("t2_held_count", 32'(count_o), 32'd1);
        done_i = 1'b0;
        apply_stimulus();
        root_i = 8'd9;
        done_i = 1'b1;
        apply_stimulus();
        check_eq("t2_second_count", 32'(count_o), 32'd2);
        done_i = 1'b0;
        bus.res_ready = 1'b1;
        repeat (2) apply_stimulus();
        bus.res_ready = 1'b0;

        // Fill, overflow on the fifth capture, then drain in order.
        for (int v = 1; v <= 4; v++) pulse_capture(8'(v));
        check_eq("t3_full", 32'(full_o), 32'd1);
        pulse_capture(8'd5);
        check_eq("t3_overflow", 32'(overflow_o), 32'd1);
        check_eq("t3_count", 32'(count_o), 32'd4);
        check_eq("t3_head", 32'(bus.res_data), 32'd1);
        bus.res_ready = 1'b1;
        repeat (4) apply_stimulus();
        bus.res_ready = 1'b0;
        check_eq("t3_empty", 32'(empty_o), 32'd1);
`ifdef SQRT_DROP_CNT_EN
        check_eq("t3_drop_cnt", 32'(drop_cnt_o), 32'd1);
`endif
        clear_i = 1'b1;
        apply_stimulus();
        clear_i = 1'b0;

        // Capture into a full queue while the head is popped.
        for (int v = 1; v <= 4; v++) pulse_capture(8'(10 + v));
        root_i = 8'd200;
        done_i = 1'b1;
        bus.res_ready = 1'b1;
        apply_stimulus();
        check_eq("t4_no_overflow", 32'(overflow_o), 32'd0);
        check_eq("t4_count", 32'(count_o), 32'd4);
        done_i = 1'b0;
        repeat (3) apply_stimulus();
        check_eq("t4_last", 32'(bus.res_data), 32'd200);
        apply_stimulus();
        bus.res_ready = 1'b0;

        // Clear coinciding with a capture.
        for (int v = 1; v <= 3; v++) pulse_capture(8'(30 + v));
        clear_i = 1'b1;
        root_i  = 8'd55;
        done_i  = 1'b1;
        apply_stimulus();
        check_eq("t5_count", 32'(count_o), 32'd0);
        check_eq("t5_empty", 32'(empty_o), 32'd1);
        clear_i = 1'b0;
        done_i  = 1'b0;
        apply_stimulus();

        // Asynchronous reset mid-queue with done held high.
        pulse_capture(8'd70);
        pulse_capture(8'd71);
        root_i = 8'd77;
        done_i = 1'b1;
        apply_stimulus();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_output();
        check_eq("t6_async_valid", 32'(bus.res_valid), 32'd0);
        check_eq("t6_async_data", 32'(bus.res_data), 32'd0);
        @(posedge clk);
        #1;
        check_output();
        rst = 1'b0;
        repeat (3) apply_stimulus();
        check_eq("t6_no_capture", 32'(count_o), 32'd0);
        done_i = 1'b0;
        apply_stimulus();
        root_i = 8'd88;
        done_i = 1'b1;
        apply_stimulus();
        check_eq("t6_recapture_data", 32'(bus.res_data), 32'd88);
        done_i = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            root_i        = 8'($urandom);
            done_i        = ($urandom_range(0, 2) == 0);
            bus.res_ready = ($urandom_range(0, 2) == 0);
            clear_i       = ($urandom_range(0, 40) == 0);
            apply_stimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
